pio_cmd_fifo: RTL and testbench
===============================

PIO_CMD_FIFO -- requirements
Module: pio_cmd_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, range 2..16.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port pio_in  in  16  command word from the upstream PIO out_port; bit 15 = command toggle, bits 14:0 = payload.
REQ-005 SHALL have port cmd_data  out  15  payload at FIFO head.
REQ-006 SHALL have port cmd_valid  out  1  FIFO non-empty.
REQ-007 SHALL have port cmd_ready  in  1  consumer accepts the head entry.
REQ-008 SHALL have port status  out  16  status word for a PIO input port back to software.

Function
REQ-009 SHALL hold register tog_q, loaded with pio_in[15] every cycle.
REQ-010 SHALL detect a command event on any edge where pio_in[15] != tog_q; exactly one event per toggle.
REQ-011 SHALL treat an event with payload 0x7FFF as a clear command: clears the overflow flag (and the drop counter, REQ-024); not enqueued.
REQ-012 SHALL enqueue any other event payload at that edge if count < DEPTH, or if count == DEPTH and a pop occurs on the same edge.
REQ-013 SHALL drop the event when the FIFO is full with no same-edge pop, set overflow flag, and leave FIFO contents and count unchanged.
REQ-014 SHALL pop on any edge where cmd_valid && cmd_ready; cmd_ready while empty has no effect.
REQ-015 SHALL be first-word-fall-through: cmd_data = head entry whenever cmd_valid = 1; cmd_data is don't-care when empty.
REQ-016 SHALL assert cmd_valid in the cycle after the edge that enqueues into an empty FIFO (latency 1 clock from event sampling).
REQ-017 SHALL, on simultaneous push and pop, keep count unchanged and preserve FIFO order.
REQ-018 SHALL wrap read and write pointers modulo DEPTH.
REQ-019 SHALL drive status as follows: [15] = tog_q (software handshake echo); [14] = overflow; [13] = empty; [12] = full; [11:8] per REQ-024; [7:5] = 0; [4:0] = count (0..DEPTH).
REQ-020 SHALL register all status bits; none may be combinational from pio_in.

Reset
REQ-021 SHALL, while reset is high, asynchronously clear tog_q, pointers, count, overflow and drop counter; cmd_valid = 0; status = 0x2000 (empty only).
REQ-022 SHALL discard FIFO contents and any in-flight event when reset asserts mid-operation; the first post-reset edge with pio_in[15] = 1 counts as an event.

Configuration
REQ-023 SHALL compile the drop counter only when macro PIO_CMD_FIFO_DROP_CNT_EN is defined.
REQ-024 SHALL, with PIO_CMD_FIFO_DROP_CNT_EN defined, maintain a 4-bit drop counter on status[11:8]: +1 per dropped event, saturating at 15, cleared by reset and by the clear command; without the macro, status[11:8] = 0 and no counter logic exists.

Verification
REQ-025 SHALL cover: after reset, pio_in = 0x8005 -> cmd_valid = 1 one clock later, cmd_data = 0x0005, status = 0x8001; then cmd_ready = 1 for one edge -> cmd_valid = 0, status = 0xA000.
REQ-026 SHALL cover: DEPTH = 4, five toggles with payloads 1..5 and cmd_ready = 0 -> status[12] = 1, [14] = 1, count = 4; pops return 1, 2, 3, 4; with macro, status[11:8] = 1.
REQ-027 SHALL cover: FIFO full, event and pop on the same edge -> no overflow, count stays 4, new payload read last.
REQ-028 SHALL cover: overflow set, then toggle with payload 0x7FFF -> status[14] = 0, drop counter = 0, count unchanged, payload not enqueued.
REQ-029 SHALL cover: pio_in held constant for 20 cycles after one toggle -> exactly one enqueue.
REQ-030 SHALL cover: reset pulsed with 3 entries queued -> cmd_valid drops immediately, status = 0x2000 while reset is high.

Source files
------------

// File: rtl/pio_cmd_fifo.sv
// Command FIFO fed by a toggle-handshake PIO word; FWFT read side plus a status word.
// Optional drop counter on status[11:8] is built only when PIO_CMD_FIFO_DROP_CNT_EN is defined.
module pio_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pio_in,
    output logic [14:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [15:0] status
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic          tog_q;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [4:0]    count;
    logic          overflow;
    logic [3:0]    drop_cnt;
    logic [14:0]   mem [DEPTH];

    logic cmd_event;
    logic clear_cmd;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        cmd_event = (pio_in[15] != tog_q);
        clear_cmd = cmd_event && (pio_in[14:0] == 15'h7FFF);
        empty     = (count == 5'd0);
        full      = (count == DEPTH_C);
        pop       = !empty && cmd_ready;
        // A full FIFO still accepts a new word when the head leaves on the same edge.
        push      = cmd_event && !clear_cmd && (!full || pop);
        drop      = cmd_event && !clear_cmd && full && !pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tog_q    <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
        end else begin
            tog_q <= pio_in[15];
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (clear_cmd)
                overflow <= 1'b0;
            else if (drop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= pio_in[14:0];
    end

`ifdef PIO_CMD_FIFO_DROP_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_cnt <= 4'h0;
        else if (clear_cmd)
            drop_cnt <= 4'h0;
        else if (drop && (drop_cnt != 4'hF))
            drop_cnt <= drop_cnt + 4'h1;
    end
`else
    assign drop_cnt = 4'h0;
`endif

    assign cmd_valid = !empty;
    assign cmd_data  = mem[rptr];
    assign status    = {tog_q, overflow, empty, full, drop_cnt, 3'b000, count};

endmodule

// File: tb/tb_pio_cmd_fifo.sv
// Self-checking bench for pio_cmd_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pio_cmd_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pio_in;
    logic [14:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] status;

    int checks = 0;
    int errors = 0;

    logic [14:0] mq[$];
    logic        m_tog;
    logic        m_ovf;
    int          m_drops;
    logic [15:0] cur;

    pio_cmd_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .pio_in    (pio_in),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .status    (status)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic m_reset();
        mq.delete();
        m_tog   = 1'b0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_step(input logic [15:0] p, input logic r);
        bit          popped;
        bit          accept;
        logic [14:0] tmp;
        popped = (mq.size() != 0) && r;
        accept = 1'b0;
        if (p[15] != m_tog) begin
            if (p[14:0] == 15'h7FFF) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end else if (mq.size() < DEPTH || popped) begin
                accept = 1'b1;
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 15) m_drops++;
            end
        end
        if (popped) tmp = mq.pop_front();
        if (accept) mq.push_back(p[14:0]);
        m_tog = p[15];
    endtask

    function automatic logic [15:0] exp_status();
        logic [3:0] d;
`ifdef PIO_CMD_FIFO_DROP_CNT_EN
        d = 4'(m_drops);
`else
        d = 4'h0;
`endif
        return {m_tog, m_ovf, (mq.size() == 0), (mq.size() == DEPTH), d, 3'b000, 5'(mq.size())};
    endfunction

    function automatic logic [3:0] exp_drops();
`ifdef PIO_CMD_FIFO_DROP_CNT_EN
        return 4'(m_drops);
`else
        return 4'h0;
`endif
    endfunction

    task automatic tick(input logic [15:0] p, input logic r);
        pio_in    = p;
        cmd_ready = r;
        @(posedge clk);
        model_step(p, r);
        #1;
    endtask

    function automatic logic [15:0] toggled(input logic [15:0] c, input logic [14:0] pay);
        return {~c[15], pay};
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if (status !== 16'h2000 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async status=%h valid=%b want 2000/0", status, cmd_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (status !== 16'h2000) begin
            errors++;
            $display("FAIL reset_hold status=%h want 2000", status);
        end
        reset = 1'b0;
        m_reset();
        cur = 16'h0000;
    endtask

    task automatic test_basic();
        cur = 16'h8005;
        tick(cur, 1'b0);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_data !== 15'h0005 || status !== 16'h8001) begin
            errors++;
            $display("FAIL basic_push valid=%b data=%h status=%h want 1/0005/8001", cmd_valid, cmd_data, status);
        end
        tick(cur, 1'b1);
        checks++;
        if (cmd_valid !== 1'b0 || status !== 16'hA000) begin
            errors++;
            $display("FAIL basic_pop valid=%b status=%h want 0/a000", cmd_valid, status);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            cur = toggled(cur, 15'(i));
            tick(cur, 1'b0);
        end
        checks++;
        if (status[12] !== 1'b1 || status[14] !== 1'b1 || status[4:0] !== 5'd4 || status[11:8] !== exp_drops()) begin
            errors++;
            $display("FAIL overflow_status status=%h want full=1 ovf=1 count=4 drops=%0d", status, exp_drops());
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_data !== 15'(i)) begin
                errors++;
                $display("FAIL overflow_pop%0d valid=%b data=%h want 1/%h", i, cmd_valid, cmd_data, 15'(i));
            end
            tick(cur, 1'b1);
        end
        checks++;
        if (cmd_valid !== 1'b0 || status[14] !== 1'b1) begin
            errors++;
            $display("FAIL overflow_drained valid=%b status=%h want 0 ovf=1", cmd_valid, status);
        end
    endtask

    task automatic test_clear();
        cur = toggled(cur, 15'h00AA);
        tick(cur, 1'b0);
        cur = toggled(cur, 15'h7FFF);
        tick(cur, 1'b0);
        checks++;
        if (status[14] !== 1'b0 || status[11:8] !== 4'h0 || status[4:0] !== 5'd1 || cmd_data !== 15'h00AA) begin
            errors++;
            $display("FAIL clear_cmd status=%h data=%h want ovf=0 drops=0 count=1 data=00aa", status, cmd_data);
        end
        tick(cur, 1'b1);
        checks++;
        if (cmd_valid !== 1'b0 || status !== exp_status()) begin
            errors++;
            $display("FAIL clear_drain valid=%b status=%h want 0/%h", cmd_valid, status, exp_status());
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) begin
            cur = toggled(cur, 15'(16'h0010 + i));
            tick(cur, 1'b0);
        end
        cur = toggled(cur, 15'h0014);
        tick(cur, 1'b1);
        checks++;
        if (status[4:0] !== 5'd4 || status[14] !== 1'b0 || status[11:8] !== 4'h0 || cmd_data !== 15'h0011) begin
            errors++;
            $display("FAIL full_push_pop status=%h data=%h want count=4 ovf=0 data=0011", status, cmd_data);
        end
        for (int k = 16'h11; k <= 16'h14; k++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_data !== 15'(k)) begin
                errors++;
                $display("FAIL full_drain valid=%b data=%h want 1/%h", cmd_valid, cmd_data, 15'(k));
            end
            tick(cur, 1'b1);
        end
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_empty valid=%b want 0", cmd_valid);
        end
    endtask

    task automatic test_hold();
        cur = toggled(cur, 15'h0123);
        tick(cur, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(cur, 1'b0);
            checks++;
            if (status[4:0] !== 5'd1) begin
                errors++;
                $display("FAIL hold_count cycle=%0d count=%0d want 1", i, status[4:0]);
            end
        end
        tick(cur, 1'b1);
        checks++;
        if (cmd_valid !== 1'b0 || status !== exp_status()) begin
            errors++;
            $display("FAIL hold_pop valid=%b status=%h want 0/%h", cmd_valid, status, exp_status());
        end
    endtask

    task automatic test_random();
        logic r;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                if ($urandom_range(0, 9) == 0)
                    cur = toggled(cur, 15'h7FFF);
                else
                    cur = toggled(cur, 15'($urandom_range(0, 32766)));
            end else if ($urandom_range(0, 3) == 0) begin
                cur = {cur[15], 15'($urandom_range(0, 32767))};
            end
            r = ($urandom_range(0, 2) == 0);
            tick(cur, r);
            checks++;
            if (cmd_valid !== (mq.size() != 0) || status !== exp_status() ||
                (mq.size() != 0 && cmd_data !== mq[0])) begin
                errors++;
                $display("FAIL random cycle=%0d valid=%b data=%h status=%h want %b/%h/%h",
                         i, cmd_valid, cmd_data, status, (mq.size() != 0),
                         (mq.size() != 0) ? mq[0] : 15'h0, exp_status());
            end
        end
    endtask

    task automatic test_async_reset();
        while (mq.size() != 0) tick(cur, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cur = toggled(cur, 15'(16'h0030 + i));
            tick(cur, 1'b0);
        end
        checks++;
        if (status[4:0] !== 5'd3) begin
            errors++;
            $display("FAIL areset_fill count=%0d want 3", status[4:0]);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || status !== 16'h2000) begin
            errors++;
            $display("FAIL areset_immediate valid=%b status=%h want 0/2000", cmd_valid, status);
        end
        pio_in = 16'h8042;
        @(posedge clk);
        #1;
        checks++;
        if (status !== 16'h2000) begin
            errors++;
            $display("FAIL areset_held status=%h want 2000", status);
        end
        reset = 1'b0;
        m_reset();
        cur = 16'h8042;
        tick(cur, 1'b0);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_data !== 15'h0042 || status !== 16'h8001) begin
            errors++;
            $display("FAIL areset_first_event valid=%b data=%h status=%h want 1/0042/8001", cmd_valid, cmd_data, status);
        end
    endtask

    initial begin
        reset     = 1'b1;
        pio_in    = 16'h0000;
        cmd_ready = 1'b0;
        m_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_clear();
        test_full_push_pop();
        test_hold();
        test_random();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
